// File: rtl/dac_spi_tx.sv
// Serial MCP4921-class DAC writer: one 16-bit mode-0 SPI frame {CONFIG, sample} per valid/ready accept.
// Frame period (34+CS_GAP)*CLK_DIV+1 cycles; ready is low for the whole frame and gap, so valid is simply ignored then.
module dac_spi_tx #(
  parameter int         DATA_WIDTH = 12,
  parameter int         CLK_DIV    = 4,
  parameter logic [3:0] CONFIG     = 4'b0011,
  parameter int         CS_GAP     = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid,
  output logic                  ready,
  output logic                  done,
  output logic                  dac_clk,
  output logic                  dac_cs_n,
  output logic                  dac_sdi
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int HP_W  = $clog2(34 + CS_GAP + 1);

  localparam logic [DIV_W-1:0] DIV_LAST     = DIV_W'(CLK_DIV - 1);
  localparam logic [HP_W-1:0]  HP_LAST_FALL = HP_W'(32);
  localparam logic [HP_W-1:0]  HP_CS_RISE   = HP_W'(34);
  localparam logic [HP_W-1:0]  HP_GAP_END   = HP_W'(34 + CS_GAP);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [HP_W-1:0]   hp_q, hp_d;
  logic [14:0]       sreg_q, sreg_d;
  logic              clk_q, clk_d;
  logic              cs_n_q, cs_n_d;
  logic              sdi_q, sdi_d;
  logic              done_q, done_d;

  logic              tick;
  logic [11:0]       sample_lj;
  logic [15:0]       word;

  assign tick      = (div_q == DIV_LAST);
  assign sample_lj = 12'(data_in) << (12 - DATA_WIDTH);
  assign word      = {CONFIG, sample_lj};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      div_q   <= '0;
      hp_q    <= '0;
      sreg_q  <= '0;
      clk_q   <= 1'b0;
      cs_n_q  <= 1'b1;
      sdi_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      hp_q    <= hp_d;
      sreg_q  <= sreg_d;
      clk_q   <= clk_d;
      cs_n_q  <= cs_n_d;
      sdi_q   <= sdi_d;
      done_q  <= done_d;
    end
  end

  // hp_q counts half-periods since the accept edge; every phase boundary is an absolute half-period index.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    hp_d    = hp_q;
    sreg_d  = sreg_q;
    clk_d   = clk_q;
    cs_n_d  = cs_n_q;
    sdi_d   = sdi_q;
    done_d  = 1'b0;

    if (state_q != IDLE) begin
      div_d = tick ? '0 : div_q + 1'b1;
      if (tick) hp_d = hp_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (valid) begin
          state_d = SETUP;
          div_d   = '0;
          hp_d    = '0;
          sreg_d  = word[14:0];
          sdi_d   = word[15];
          cs_n_d  = 1'b0;
        end
      end
      SETUP: begin
        if (tick) begin
          clk_d   = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (tick) begin
          clk_d = ~clk_q;
          if (clk_q) begin
            if (hp_d == HP_LAST_FALL) begin
              state_d = HOLD;
            end else begin
              sdi_d  = sreg_q[14];
              sreg_d = {sreg_q[13:0], 1'b0};
            end
          end
        end
      end
      HOLD: begin
        // Last bit stays on dac_sdi with dac_clk low until chip select releases at half-period 34.
        if (tick && hp_d == HP_CS_RISE) begin
          cs_n_d  = 1'b1;
          sdi_d   = 1'b0;
          done_d  = 1'b1;
          state_d = GAP;
        end
      end
      GAP: begin
        if (tick && hp_d == HP_GAP_END) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign ready    = (state_q == IDLE);
  assign done     = done_q;
  assign dac_clk  = clk_q;
  assign dac_cs_n = cs_n_q;
  assign dac_sdi  = sdi_q;

endmodule

// File: tb/tb_dac_spi_tx.sv
// Bench for dac_spi_tx: default instance plus a CLK_DIV=1 / DATA_WIDTH=8 instance, both checked every cycle
// against a waveform model derived from the frame timing rules, plus an SPI capture monitor.
module tb_dac_spi_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  resetn;
  logic [1:0]  valid;
  logic [11:0] din0;
  logic [7:0]  din1;
  wire  [1:0]  ready, done, dclk, cs_n, sdi;
  logic [11:0] lj [2];

  assign lj[0] = din0;
  assign lj[1] = {din1, 4'h0};

  int tests = 0;
  int fails = 0;

  int          ncap [2];
  int          dcnt [2];
  int          gap  [2];
  logic [15:0] cap_hist [2][8];

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  dac_spi_tx dut (
    .clk(clk), .resetn(resetn[0]), .data_in(din0), .valid(valid[0]), .ready(ready[0]),
    .done(done[0]), .dac_clk(dclk[0]), .dac_cs_n(cs_n[0]), .dac_sdi(sdi[0])
  );

  dac_spi_tx #(.DATA_WIDTH(8), .CLK_DIV(1)) dut6 (
    .clk(clk), .resetn(resetn[1]), .data_in(din1), .valid(valid[1]), .ready(ready[1]),
    .done(done[1]), .dac_clk(dclk[1]), .dac_cs_n(cs_n[1]), .dac_sdi(sdi[1])
  );

  for (genvar g = 0; g < 2; g++) begin : g_m
    localparam int D     = (g == 0) ? 4 : 1;
    localparam int LOWC  = 34 * D;
    localparam int BUSYC = 36 * D;

    bit          busy = 1'b0;
    int          k    = 0;
    logic [15:0] word = '0;
    logic [15:0] expq [$];
    logic [15:0] sh   = '0;
    int          nr   = 0;
    int          run  = 0;

    // Model: k = clock edges since the accept edge; outputs are a pure function of k and the word.
    always @(posedge clk) begin
      if (resetn[g] !== 1'b1) begin
        busy = 1'b0;
        expq.delete();
      end else if (busy) begin
        k++;
        if (k == BUSYC) busy = 1'b0;
      end else if (valid[g] === 1'b1) begin
        busy = 1'b1;
        k    = 0;
        word = {4'b0011, lj[g]};
        expq.push_back(word);
      end
    end

    always @(negedge clk) begin : cmp
      logic [4:0] e;
      int h;
      int b;
      e = 5'b10010;
      if (resetn[g] === 1'b1 && busy) begin
        h    = k / D;
        b    = (h / 2 > 15) ? 15 : h / 2;
        e[4] = 1'b0;
        e[3] = (k == LOWC);
        e[2] = (k < LOWC) && (h % 2 == 1) && (h <= 31);
        e[1] = (k >= LOWC);
        e[0] = (k < LOWC) ? word[15 - b] : 1'b0;
      end
      chk((g == 0) ? "outs0{rdy,done,clk,cs_n,sdi}" : "outs1{rdy,done,clk,cs_n,sdi}",
          {ready[g], done[g], dclk[g], cs_n[g], sdi[g]}, e);
      if (done[g] === 1'b1) dcnt[g]++;
      if (cs_n[g] === 1'b1) run++;
    end

    always @(negedge cs_n[g]) begin
      gap[g] = run;
      sh     = '0;
      nr     = 0;
    end

    always @(posedge dclk[g]) begin
      sh = {sh[14:0], sdi[g]};
      nr++;
    end

    always @(posedge cs_n[g]) begin
      run = 0;
      if (resetn[g] === 1'b1) begin
        chk("rise_count", nr, 16);
        chk("frame_pending", (expq.size() > 0), 1);
        if (expq.size() > 0) chk("frame_word", sh, expq.pop_front());
        cap_hist[g][ncap[g] % 8] = sh;
        ncap[g]++;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_ready(input int g, input int budget);
    int n;
    n = 0;
    while (ready[g] !== 1'b1 && n < budget) begin
      cyc(1);
      n++;
    end
    chk("ready_wait", ready[g], 1);
  endtask

  task automatic accept(input int g, input logic [11:0] d, input bit hold);
    if (g == 0) din0 = d; else din1 = d[7:0];
    valid[g] = 1'b1;
    wait_ready(g, 400);
    cyc(1);
    if (!hold) valid[g] = 1'b0;
    if (g == 0) din0 = 12'($urandom); else din1 = 8'($urandom);
  endtask

  task automatic wait_frames(input int g, input int target);
    int n;
    n = 0;
    while (ncap[g] < target && n < 2000) begin
      cyc(1);
      n++;
    end
    chk("frames_seen", ncap[g], target);
  endtask

  task automatic rnd(input int g, input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      valid[g] = ($urandom_range(0, 3) == 0);
      if (g == 0) din0 = 12'($urandom); else din1 = 8'($urandom);
      cyc(1);
    end
    valid[g] = 1'b0;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, d0, n, r, t1, t2;
    logic prev;
    for (int i = 0; i < 2; i++) begin
      ncap[i] = 0;
      dcnt[i] = 0;
      gap[i]  = 0;
    end
    resetn = 2'b00;
    valid  = 2'b00;
    din0   = '0;
    din1   = '0;
    repeat (3) @(posedge clk);
    #1;

    // T1: reset values, and nothing moves after release without an accept
    chk("rst_ready", ready[0], 1);
    chk("rst_done", done[0], 0);
    chk("rst_dac_clk", dclk[0], 0);
    chk("rst_cs_n", cs_n[0], 1);
    chk("rst_sdi", sdi[0], 0);
    resetn = 2'b11;
    cyc(6);
    chk("idle_cs_n", cs_n[0], 1);
    chk("idle_ready", ready[0], 1);

    // T2: single frame, chip-select width and ready return
    c0 = ncap[0];
    accept(0, 12'hA5C, 1'b0);
    n = 0;
    while (cs_n[0] === 1'b0 && n < 400) begin
      cyc(1);
      n++;
    end
    chk("t2_cs_low_cycles", n, 136);
    while (ready[0] !== 1'b1 && n < 400) begin
      cyc(1);
      n++;
    end
    chk("t2_ready_return", n + 1, 145);
    chk("t2_frames", ncap[0], c0 + 1);
    chk("t2_word", cap_hist[0][c0 % 8], 16'h3A5C);

    // T3: back-to-back with valid held
    c0 = ncap[0];
    d0 = dcnt[0];
    accept(0, 12'h000, 1'b1);
    accept(0, 12'hFFF, 1'b1);
    chk("t3_cs_gap", gap[0], 9);
    accept(0, 12'h800, 1'b0);
    wait_frames(0, c0 + 3);
    cyc(2);
    chk("t3_word0", cap_hist[0][c0 % 8], 16'h3000);
    chk("t3_word1", cap_hist[0][(c0 + 1) % 8], 16'h3FFF);
    chk("t3_word2", cap_hist[0][(c0 + 2) % 8], 16'h3800);
    chk("t3_done_pulses", dcnt[0] - d0, 3);

    // T4: valid while busy is ignored
    c0 = ncap[0];
    accept(0, 12'h9E1, 1'b0);
    cyc(60);
    din0     = 12'h123;
    valid[0] = 1'b1;
    cyc(1);
    valid[0] = 1'b0;
    wait_frames(0, c0 + 1);
    cyc(200);
    chk("t4_frames", ncap[0], c0 + 1);
    chk("t4_word", cap_hist[0][c0 % 8], 16'h39E1);

    // T5: abort at the 7th rising dac_clk
    c0 = ncap[0];
    accept(0, 12'h7F0, 1'b0);
    r = 0;
    n = 0;
    prev = dclk[0];
    while (r < 7 && n < 400) begin
      cyc(1);
      n++;
      if (dclk[0] === 1'b1 && prev === 1'b0) r++;
      prev = dclk[0];
    end
    chk("t5_rises_before_abort", r, 7);
    resetn[0] = 1'b0;
    #1;
    chk("t5_abort_cs_n", cs_n[0], 1);
    chk("t5_abort_dac_clk", dclk[0], 0);
    chk("t5_abort_ready", ready[0], 1);
    @(posedge clk);
    #1;
    cyc(2);
    resetn[0] = 1'b1;
    cyc(2);
    chk("t5_no_capture", ncap[0], c0);
    accept(0, 12'h456, 1'b0);
    wait_frames(0, c0 + 1);
    chk("t5_word", cap_hist[0][c0 % 8], 16'h3456);
    cyc(20);

    // T6: CLK_DIV=1, DATA_WIDTH=8
    c0 = ncap[1];
    accept(1, 12'h0C3, 1'b0);
    n = 0;
    t1 = -1;
    t2 = -1;
    prev = dclk[1];
    while (ready[1] !== 1'b1 && n < 200) begin
      cyc(1);
      n++;
      if (dclk[1] === 1'b1 && prev === 1'b0) begin
        if (t1 < 0) t1 = n;
        else if (t2 < 0) t2 = n;
      end
      prev = dclk[1];
    end
    chk("t6_first_rise", t1, 1);
    chk("t6_sclk_period", t2 - t1, 2);
    chk("t6_ready_return", n + 1, 37);
    chk("t6_frames", ncap[1], c0 + 1);
    chk("t6_word", cap_hist[1][c0 % 8], 16'h3C30);

    // Random traffic on both instances against the model
    fork
      rnd(0, 2500);
      rnd(1, 2500);
    join
    cyc(200);
    chk("rand_frames0", (ncap[0] > c0), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
